display_timing: RTL

Raster timing generator for the 640x480 @ 60 Hz VGA output. Divides the board clock down to the pixel rate, produces the free-running `hCount`/`vCount` raster position, drives `hSync`/`vSync` to the connector, and produces `bright` as the active-video qualifier. The object/colour logic consumes `hCount`, `vCount` and `bright` to compute `rgb`, and can use `frame_tick` as a once-per-frame enable for object motion.

---
 rtl/display_timing.sv | 71 +++++++
 1 files changed

// File: rtl/display_timing.sv
// display_timing: 640x480@60 VGA raster timing generator with a board-clock-to-pixel divider.
module display_timing #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       line_tick,
  output logic       frame_tick
);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS       = 10'(H_SYNC);
  localparam logic [9:0] VS       = 10'(V_SYNC);
  localparam logic [9:0] HA       = 10'(H_ACT_START);
  localparam logic [9:0] HE       = 10'(H_ACT_END);
  localparam logic [9:0] VA       = 10'(V_ACT_START);
  localparam logic [9:0] VE       = 10'(V_ACT_END);
  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       hs_q, hs_d, vs_q, vs_d, br_q, br_d;
  // An undivided clock has no divider state to hold pix_en low, so gate it with reset directly.
  assign pix_en     = (div_q == DIV_LAST) && (CLK_DIV > 1 || !rst);
  assign line_tick  = pix_en && (h_q == H_LAST);
  assign frame_tick = line_tick && (v_q == V_LAST);
  assign hCount     = h_q;
  assign vCount     = v_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;
  assign bright     = br_q;
  // Qualifiers are decoded from next-state counters so they stay aligned with hCount/vCount.
  always_comb begin
    div_d = pix_en ? 4'd0 : div_q + 4'd1;
    h_d   = pix_en ? ((h_q == H_LAST) ? 10'd0 : h_q + 10'd1) : h_q;
    v_d   = line_tick ? ((v_q == V_LAST) ? 10'd0 : v_q + 10'd1) : v_q;
    hs_d  = h_d >= HS;
    vs_d  = v_d >= VS;
    br_d  = (h_d >= HA) && (h_d < HE) && (v_d >= VA) && (v_d < VE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      br_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      br_q  <= br_d;
    end
  end
endmodule
